// File: rtl/multi_frame_video_streamer.sv
// Purpose: replays NUM_FRAMES stored images as Avalon-ST video frames with {R,G,B} channel expansion.
// Latency: first beat two cycles after enable is sampled in IDLE, then one beat per cycle across frames.
// Backpressure: a 2-entry skid buffer and credit-limited fetch hold the presented beat stable while ready=0.
// Ports: clk, reset_n (async active-low), enable, frame_sel[3:0] (sampled at pixel (0,0)), ready in;
//   data[3*OUT_CHAN_BITS-1:0] {R,G,B}, startofpacket, endofpacket, valid, frame_count[15:0] out.
// Option: defining STREAMER_TEST_PATTERN_EN adds input test_mode (8 vertical colour bars instead of ROM).
module multi_frame_video_streamer #(
  parameter int WIDTH         = 320,
  parameter int HEIGHT        = 240,
  parameter int NUM_FRAMES    = 4,
  parameter int SRC_CHAN_BITS = 4,
  parameter int OUT_CHAN_BITS = 10
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic [3:0]                 frame_sel,
`ifdef STREAMER_TEST_PATTERN_EN
  input  logic                       test_mode,
`endif
  output logic [3*OUT_CHAN_BITS-1:0] data,
  output logic                       startofpacket,
  output logic                       endofpacket,
  output logic                       valid,
  input  logic                       ready,
  output logic [15:0]                frame_count
);

  localparam int ROM_W     = 3 * SRC_CHAN_BITS;
  localparam int OUT_W     = 3 * OUT_CHAN_BITS;
  localparam int FRAME_PIX = WIDTH * HEIGHT;
  localparam int XW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW        = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int REP       = (OUT_CHAN_BITS + SRC_CHAN_BITS - 1) / SRC_CHAN_BITS;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_STREAM} state_t;

  // Image store: word at address a is (a*0x3A7 + 0xA5F) truncated to ROM_W bits.
  // An arithmetic fill keeps the images reproducible without an init file; the
  // registered read below maps onto a synchronous-read block ROM.
  function automatic logic [ROM_W-1:0] rom_word(input logic [31:0] addr);
    return ROM_W'(addr * 32'h0000_03A7 + 32'h0000_0A5F);
  endfunction

  // Repeat the source bits MSB-first and keep the top OUT_CHAN_BITS.
  function automatic logic [OUT_CHAN_BITS-1:0] expand(input logic [SRC_CHAN_BITS-1:0] s);
    return OUT_CHAN_BITS'({REP{s}} >> (REP * SRC_CHAN_BITS - OUT_CHAN_BITS));
  endfunction

`ifdef STREAMER_TEST_PATTERN_EN
  function automatic logic [OUT_W-1:0] bar_pixel(input logic [2:0] bar);
    return {{OUT_CHAN_BITS{bar[2]}}, {OUT_CHAN_BITS{bar[1]}}, {OUT_CHAN_BITS{bar[0]}}};
  endfunction
`endif

  state_t             state_q;
  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  logic [3:0]         frame_q;
  logic               halt_q;
  // ROM read stage: data lands in rom_q one cycle after issue.
  logic               rd_vld_q, rd_sop_q, rd_eop_q;
  logic [ROM_W-1:0]   rom_q;
  // Output head register and skid entry.
  logic               valid_q, sop_q, eop_q;
  logic [OUT_W-1:0]   data_q;
  logic               skid_vld_q, skid_sop_q, skid_eop_q;
  logic [OUT_W-1:0]   skid_data_q;
  logic [15:0]        frame_count_q;
`ifdef STREAMER_TEST_PATTERN_EN
  logic               tp_q, rd_tp_q;
  logic [2:0]         rd_bar_q;
  logic               fetch_tp;
  logic [2:0]         fetch_bar;
`endif

  logic               pop, push, at_origin, last_x, last_y;
  logic               fetch_active, credit, want, stop, issue;
  logic [1:0]         occ_d;
  logic [3:0]         sel_frame, fetch_frame;
  logic [31:0]        rd_addr;
  logic [OUT_W-1:0]   push_data;

  always_comb begin
    pop       = valid_q & ready;
    push      = rd_vld_q;
    at_origin = (x_q == '0) && (y_q == '0);
    last_x    = (x_q == XW'(WIDTH - 1));
    last_y    = (y_q == YW'(HEIGHT - 1));

    // Occupancy of head+skid after this edge; a new read may only be issued if
    // its data will still find room when it lands next cycle.
    occ_d  = 2'(valid_q) + 2'(skid_vld_q) + 2'(push) - 2'(pop);
    credit = (occ_d < 2'd2);

    // Enable is honoured at the frame boundary: the fetcher either starts the
    // next frame at (0,0) or halts, so a running frame is never truncated.
    fetch_active = (state_q == S_FETCH) || ((state_q == S_STREAM) && !halt_q);
    want         = fetch_active && credit;
    stop         = want && at_origin && (state_q == S_STREAM) && !enable;
    issue        = want && !stop;

    sel_frame   = (32'(frame_sel) < 32'(NUM_FRAMES)) ? frame_sel : 4'd0;
    fetch_frame = at_origin ? sel_frame : frame_q;
    rd_addr     = 32'(fetch_frame) * 32'(FRAME_PIX) + 32'(y_q) * 32'(WIDTH) + 32'(x_q);

    x_d = last_x ? '0 : x_q + XW'(1);
    y_d = last_x ? (last_y ? '0 : y_q + YW'(1)) : y_q;

    push_data = {expand(rom_q[ROM_W-1 -: SRC_CHAN_BITS]),
                 expand(rom_q[2*SRC_CHAN_BITS-1 -: SRC_CHAN_BITS]),
                 expand(rom_q[SRC_CHAN_BITS-1:0])};
`ifdef STREAMER_TEST_PATTERN_EN
    fetch_tp  = at_origin ? test_mode : tp_q;
    fetch_bar = 3'((32'(x_q) * 32'd8) / 32'(WIDTH));
    if (rd_tp_q) push_data = bar_pixel(rd_bar_q);
`endif
  end

  // ROM read port: no reset so it stays a plain registered block-ROM read.
  always_ff @(posedge clk) begin
    if (issue) rom_q <= rom_word(rd_addr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      frame_q       <= '0;
      halt_q        <= 1'b0;
      rd_vld_q      <= 1'b0;
      rd_sop_q      <= 1'b0;
      rd_eop_q      <= 1'b0;
      valid_q       <= 1'b0;
      sop_q         <= 1'b0;
      eop_q         <= 1'b0;
      data_q        <= '0;
      skid_vld_q    <= 1'b0;
      skid_sop_q    <= 1'b0;
      skid_eop_q    <= 1'b0;
      skid_data_q   <= '0;
      frame_count_q <= '0;
`ifdef STREAMER_TEST_PATTERN_EN
      tp_q          <= 1'b0;
      rd_tp_q       <= 1'b0;
      rd_bar_q      <= '0;
`endif
    end else begin
      // Fetch side: pixel counters advance on every issued read.
      rd_vld_q <= issue;
      if (issue) begin
        rd_sop_q <= at_origin;
        rd_eop_q <= last_x && last_y;
        x_q      <= x_d;
        y_q      <= y_d;
        if (at_origin) frame_q <= sel_frame;
`ifdef STREAMER_TEST_PATTERN_EN
        rd_tp_q  <= fetch_tp;
        rd_bar_q <= fetch_bar;
        if (at_origin) tp_q <= test_mode;
`endif
      end

      // Output side: head register drives the ports, skid catches the
      // in-flight read when the head is stalled.
      if (!valid_q || pop) begin
        if (skid_vld_q) begin
          valid_q    <= 1'b1;
          data_q     <= skid_data_q;
          sop_q      <= skid_sop_q;
          eop_q      <= skid_eop_q;
          skid_vld_q <= push;
          if (push) begin
            skid_data_q <= push_data;
            skid_sop_q  <= rd_sop_q;
            skid_eop_q  <= rd_eop_q;
          end
        end else if (push) begin
          valid_q <= 1'b1;
          data_q  <= push_data;
          sop_q   <= rd_sop_q;
          eop_q   <= rd_eop_q;
        end else begin
          valid_q <= 1'b0;
          sop_q   <= 1'b0;
          eop_q   <= 1'b0;
        end
      end else if (push) begin
        skid_vld_q  <= 1'b1;
        skid_data_q <= push_data;
        skid_sop_q  <= rd_sop_q;
        skid_eop_q  <= rd_eop_q;
      end

      if (pop && eop_q) frame_count_q <= frame_count_q + 16'd1;

      case (state_q)
        S_IDLE: begin
          halt_q <= 1'b0;
          if (enable) state_q <= S_FETCH;
        end
        // Pixel (0,0) is read here; its data lands as the state enters STREAM.
        S_FETCH: state_q <= S_STREAM;
        S_STREAM: begin
          // Leave once halted and the final (EOP) beat has drained.
          if (halt_q && !skid_vld_q && !rd_vld_q && (!valid_q || (pop && eop_q)))
            state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
      if (stop) halt_q <= 1'b1;
    end
  end

  assign data          = data_q;
  assign startofpacket = sop_q;
  assign endofpacket   = eop_q;
  assign valid         = valid_q;
  assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_multi_frame_video_streamer.sv
module tb_multi_frame_video_streamer;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int NF = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [3:0]  frame_sel;
  logic        ready;
  logic [29:0] data;
  logic        startofpacket, endofpacket, valid;
  logic [15:0] frame_count;
`ifdef STREAMER_TEST_PATTERN_EN
  logic        test_mode;
`endif

  always #5 clk = ~clk;

  multi_frame_video_streamer #(
    .WIDTH(W), .HEIGHT(H), .NUM_FRAMES(NF), .SRC_CHAN_BITS(4), .OUT_CHAN_BITS(10)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .frame_sel(frame_sel),
`ifdef STREAMER_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .data(data),
    .startofpacket(startofpacket),
    .endofpacket(endofpacket),
    .valid(valid),
    .ready(ready),
    .frame_count(frame_count)
  );

  int          checks = 0;
  int          failures = 0;
  // Reference model state: position within the frame, image being played,
  // expected completed-frame counter.
  int          beat_idx = 0;
  int          nbeats = 0;
  int          exp_fc = 0;
  int          exp_frame = 0;
  bit          exp_tp = 1'b0;
  bit          prev_stall = 1'b0;
  logic [32:0] prev_obs = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // 4-bit source channel repeated to 10 bits: abcd -> abcdabcdab.
  function automatic logic [9:0] xp(input logic [3:0] s);
    logic [11:0] t;
    t = {s, s, s};
    return t[11:2];
  endfunction

  function automatic logic [29:0] exp_pix(input int f, input int px, input bit tp);
    logic [11:0] w;
    logic [2:0]  b3;
    if (tp) begin
      b3 = 3'((px % W) * 8 / W);
      return {{10{b3[2]}}, {10{b3[1]}}, {10{b3[0]}}};
    end
    w = 12'((f * W * H + px) * 32'h3A7 + 32'hA5F);
    return {xp(w[11:8]), xp(w[7:4]), xp(w[3:0])};
  endfunction

  function automatic int map_sel(input logic [3:0] s);
    return (int'(s) < NF) ? int'(s) : 0;
  endfunction

  function automatic bit cur_tp();
`ifdef STREAMER_TEST_PATTERN_EN
    return test_mode;
`else
    return 1'b0;
`endif
  endfunction

  // One clock: drive ready, check stability under stall, score accepted beats.
  task automatic cycle(input bit rdy);
    @(negedge clk);
    ready = rdy;
    chk("frame_count", 64'(frame_count), 64'(exp_fc));
    if (prev_stall)
      chk("hold", 64'({valid, startofpacket, endofpacket, data}), 64'(prev_obs));
    prev_stall = valid && !rdy;
    prev_obs   = {1'b1, startofpacket, endofpacket, data};
    if (valid && rdy) begin
      if (beat_idx == 0) begin
        exp_frame = map_sel(frame_sel);
        exp_tp    = cur_tp();
      end
      chk("data", 64'(data), 64'(exp_pix(exp_frame, beat_idx, exp_tp)));
      chk("sop", 64'(startofpacket), 64'(beat_idx == 0));
      chk("eop", 64'(endofpacket), 64'(beat_idx == W * H - 1));
      nbeats++;
      if (beat_idx == W * H - 1) begin
        beat_idx = 0;
        exp_fc   = (exp_fc + 1) % 65536;
      end else begin
        beat_idx++;
      end
    end
  endtask

  initial begin
    int lat;
    int budget;
    int nb0;
    reset_n   = 1'b0;
    enable    = 1'b0;
    frame_sel = 4'd0;
    ready     = 1'b0;
`ifdef STREAMER_TEST_PATTERN_EN
    test_mode = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_sop", 64'(startofpacket), 64'd0);
    chk("rst_eop", 64'(endofpacket), 64'd0);
    chk("rst_data", 64'(data), 64'd0);
    chk("rst_frame_count", 64'(frame_count), 64'd0);
    reset_n = 1'b1;
    repeat (3) begin
      cycle(1'b1);
      chk("idle_valid", 64'(valid), 64'd0);
    end

    // Continuous streaming, frame_sel changes mid-frame, out-of-range select.
    enable = 1'b1;
    lat = 0;
    do begin cycle(1'b1); lat++; end while (!valid && lat < 20);
    chk("first_valid_seen", 64'(valid), 64'd1);
    chk("first_valid_latency", 64'(lat >= 3), 64'd1);
    chk("rom_A5F_expand", 64'(data), 64'(30'b1010101010_0101010101_1111111111));
    for (int i = 1; i < 32; i++) begin
      if (nbeats == 12) frame_sel = 4'd1;
      if (nbeats == 20) frame_sel = 4'd5;
      cycle(1'b1);
      chk("nogap", 64'(valid), 64'd1);
    end
    chk("beats_after_4_frames", 64'(nbeats), 64'd32);

    // Directed stall: ready 1,0,0,1 around beats 2-3.
    budget = 0;
    do begin cycle(1'b1); budget++; end while (beat_idx != 2 && budget < 50);
    cycle(1'b1);
    cycle(1'b0);
    cycle(1'b0);
    cycle(1'b1);
    chk("stall_beat3_delivered", 64'(beat_idx), 64'd4);

    // Random backpressure with random mid-frame frame_sel changes.
    budget = 0;
    while (nbeats < 120 && budget < 2000) begin
      if (beat_idx == 3) frame_sel = 4'($urandom_range(0, 15));
      cycle(1'($urandom_range(0, 1)));
      budget++;
    end
    chk("random_phase_done", 64'(nbeats >= 120), 64'd1);

    // Reset while beat 5 is presented.
    repeat (3) cycle(1'b1);
    budget = 0;
    do begin cycle(1'b1); budget++; end while (beat_idx != 5 && budget < 50);
    chk("reach_beat5", 64'(beat_idx), 64'd5);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(valid), 64'd0);
    chk("mid_rst_sop", 64'(startofpacket), 64'd0);
    chk("mid_rst_data", 64'(data), 64'd0);
    chk("mid_rst_frame_count", 64'(frame_count), 64'd0);
    beat_idx   = 0;
    exp_fc     = 0;
    prev_stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    nb0 = nbeats;
    budget = 0;
    do begin cycle(1'b1); budget++; end while (nbeats == nb0 && budget < 20);
    chk("post_rst_first_beat", 64'(nbeats), 64'(nb0 + 1));
    chk("post_rst_sop", 64'(startofpacket), 64'd1);

    // Enable dropped at beat 4: frame completes, then the stream stops.
    budget = 0;
    do begin cycle(1'b1); budget++; end while (beat_idx != 4 && budget < 50);
    enable = 1'b0;
    budget = 0;
    do begin cycle(1'b1); budget++; end while (beat_idx != 0 && budget < 50);
    chk("frame_completed", 64'(beat_idx), 64'd0);
    nb0 = nbeats;
    repeat (8) begin
      cycle(1'b1);
      chk("idle_after_eop", 64'(valid), 64'd0);
    end
    chk("no_beats_when_idle", 64'(nbeats), 64'(nb0));

    // Restart from IDLE (colour bars when the pattern option is built).
`ifdef STREAMER_TEST_PATTERN_EN
    test_mode = 1'b1;
`endif
    enable = 1'b1;
    lat = 0;
    do begin cycle(1'b1); lat++; end while (!valid && lat < 20);
    chk("restart_valid_seen", 64'(valid), 64'd1);
    chk("restart_latency", 64'(lat >= 3), 64'd1);
    chk("restart_sop", 64'(startofpacket), 64'd1);
    repeat (7) cycle(1'b1);
    chk("restart_frame_complete", 64'(beat_idx), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_frame_video_streamer.md
MULTI_FRAME_VIDEO_STREAMER -- requirements
Module: multi_frame_video_streamer

Interface
REQ-001 SHALL have parameter WIDTH, default 320, active pixels per line.
REQ-002 SHALL have parameter HEIGHT, default 240, lines per frame.
REQ-003 SHALL have parameter NUM_FRAMES, default 4, images held in ROM, range 1..16.
REQ-004 SHALL have parameter SRC_CHAN_BITS, default 4, stored bits per colour channel; ROM word = 3*SRC_CHAN_BITS, packed {R,G,B}.
REQ-005 SHALL have parameter OUT_CHAN_BITS, default 10, output bits per channel, >= SRC_CHAN_BITS.
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port reset_n  input  1  reset; asynchronous, active-low.
REQ-008 SHALL have port enable  input  1  streaming permitted at frame boundaries.
REQ-009 SHALL have port frame_sel  input  4  requested image index.
REQ-010 SHALL have port data  output  3*OUT_CHAN_BITS  Avalon-ST pixel {R,G,B}.
REQ-011 SHALL have ports startofpacket, endofpacket, valid  output  1 each  Avalon-ST framing/qualifier.
REQ-012 SHALL have port ready  input  1  sink backpressure.
REQ-013 SHALL have port frame_count  output  16  completed frames.

Function
REQ-014 SHALL hold NUM_FRAMES*WIDTH*HEIGHT ROM words, frame f at base f*WIDTH*HEIGHT, inferred as synchronous-read BRAM (registered read, no async read).
REQ-015 SHALL track x (0..WIDTH-1) and y (0..HEIGHT-1); x wraps to 0 and y increments on x==WIDTH-1; y wraps to 0 after last pixel.
REQ-016 SHALL use states IDLE, FETCH, STREAM: IDLE->FETCH when enable=1; FETCH->STREAM after first read lands (1 cycle); STREAM->IDLE after endofpacket beat if enable=0, else STREAM->STREAM seamlessly into next frame.
REQ-017 SHALL transfer a beat only when valid&ready; on valid&!ready, data/startofpacket/endofpacket SHALL hold stable.
REQ-018 SHALL include a 2-entry skid buffer so sustained ready=1 yields one beat per cycle with no bubble, including across frame boundaries.
REQ-019 SHALL assert startofpacket with pixel (0,0) and endofpacket with pixel (WIDTH-1,HEIGHT-1), each on exactly one beat per frame.
REQ-020 SHALL sample frame_sel only when fetching pixel (0,0); frame_sel >= NUM_FRAMES SHALL select frame 0; mid-frame changes SHALL have no effect.
REQ-021 SHALL expand each channel by repeating the SRC_CHAN_BITS source bits MSB-first, truncated to OUT_CHAN_BITS (4->10: abcd -> abcdabcdab).
REQ-022 SHALL increment frame_count on each endofpacket beat, wrapping 0xFFFF->0.
REQ-023 SHALL keep valid=0 in IDLE and FETCH; enable low mid-frame SHALL NOT truncate the frame.
REQ-024 SHALL have first valid no earlier than 2 cycles after enable is sampled high in IDLE.

Reset
REQ-025 SHALL, on reset_n=0, asynchronously force valid=0, startofpacket=0, endofpacket=0, data=0, frame_count=0, x=y=0, skid empty, state IDLE.
REQ-026 SHALL, on reset mid-frame, discard the partial frame; next frame after release starts at (0,0) with startofpacket.
REQ-027 SHALL leave ROM contents unaffected by reset.

Configuration
REQ-028 SHALL, with macro STREAMER_TEST_PATTERN_EN defined, add input test_mode (1 bit); when sampled 1 at (0,0) the frame SHALL be 8 vertical colour bars (bar = x*8/WIDTH, R=bar[2], G=bar[1], B=bar[0], each bit replicated to OUT_CHAN_BITS) instead of ROM data, same timing.
REQ-029 SHALL, without STREAMER_TEST_PATTERN_EN, have no test_mode port and no pattern logic; always stream ROM.

Verification (WIDTH=4, HEIGHT=2, NUM_FRAMES=2, SRC 4, OUT 10)
REQ-030 SHALL cover: enable=1, ready=1 constant -> 8 consecutive beats, SOP on beat 0, EOP on beat 7, next SOP on beat 8 with no gap, frame_count=1 after beat 7.
REQ-031 SHALL cover: ready toggled 1,0,0,1 during beats 2-3 -> data/SOP/EOP held while ready=0; 8 distinct ROM words delivered in order, none dropped or duplicated.
REQ-032 SHALL cover: frame_sel 0->1 at beat 3 -> frame continues from frame 0; next frame reads frame 1 words; frame_sel=5 -> frame 0.
REQ-033 SHALL cover: ROM word 0xA5F -> data = {1010101010, 0101010101, 1111111111}.
REQ-034 SHALL cover: reset_n low at beat 5 -> valid=0 same cycle, frame_count=0; after release next beat is pixel (0,0) with SOP.
REQ-035 SHALL cover: enable=0 at beat 4 -> frame completes through EOP, then valid=0, state IDLE; with STREAMER_TEST_PATTERN_EN, test_mode=1 -> beats carry bars 0,2,4,6.
